// File: rtl/ddsc_freq_sink_if.sv
// Avalon-MM bus bundle between the descriptor core's data master and the frequency sink.
// The responder ignores byteenable and burstcount, so only the master modport carries them.
interface avmm_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic            write;
    logic [DW-1:0]   writedata;
    logic            read;
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic [3:0]      burstcount;
    logic            waitrequest;
    logic [31:0]     readdata;
    logic            readdatavalid;

    modport master (
        output write, writedata, read, address, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  write, writedata, read, address,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ddsc_freq_sink.sv
// Frequency-word sink: buffers written words, scales them into DDS tuning words and
// releases them either on each sync strobe or as fast as the 3-stage pipeline allows.
module ddsc_freq_sink #(
    parameter int DW      = 32,
    parameter int FIFO_AW = 2,
    parameter int SCALE_W = 32,
    parameter int SHIFT   = 32,
    parameter int FTW_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    avmm_if.slave              data_in_i,
    input  logic               sync,
    input  logic               apply_on_sync,
    input  logic [SCALE_W-1:0] ftw_scale,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_stb,
    output logic               underrun
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = DW + SCALE_W;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               full, empty, push, pop;

    logic [DW-1:0]      f_reg;
    logic [PW-1:0]      prod_reg;
    logic               s0_valid_reg, s1_valid_reg;
    logic [FTW_W-1:0]   ftw_reg;
    logic               ftw_stb_reg;
    logic               underrun_reg;
    logic [15:0]        underrun_cnt_reg;
    logic               underrun_next;
    logic [31:0]        readdata_reg, readdata_next;
    logic               readdatavalid_reg;
    logic [5:0]         count6;
    logic               unused_prod;

    // Status flags come from the registered count, so a push in the same cycle never
    // hides fullness or emptiness.
    assign full  = (count_reg == (FIFO_AW + 1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = data_in_i.write && !full;
    assign pop   = !empty && (apply_on_sync ? sync : 1'b1);
    assign underrun_next = apply_on_sync && sync && empty;

    assign data_in_i.waitrequest   = full;
    assign data_in_i.readdata      = readdata_reg;
    assign data_in_i.readdatavalid = readdatavalid_reg;
    assign ftw      = ftw_reg;
    assign ftw_stb  = ftw_stb_reg;
    assign underrun = underrun_reg;

    // Storage and its registered read port are left unreset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= data_in_i.writedata;
        if (pop)
            f_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Scale is sampled when the word enters the multiply stage, not when it was popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
            prod_reg     <= '0;
            ftw_reg      <= '0;
            ftw_stb_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= pop;
            s1_valid_reg <= s0_valid_reg;
            if (s0_valid_reg)
                prod_reg <= PW'(f_reg) * PW'(ftw_scale);
            ftw_stb_reg <= s1_valid_reg;
            if (s1_valid_reg)
                ftw_reg <= prod_reg[SHIFT +: FTW_W];
        end
    end

    assign unused_prod = ^prod_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            underrun_reg <= underrun_next;
            if (underrun_next && underrun_cnt_reg != 16'hFFFF)
                underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
        end
    end

    // The last tuning word read back is the output register itself; they never differ.
    assign count6 = 6'(count_reg);

    always_comb begin
        readdata_next = '0;
        case (data_in_i.address)
            '0:      readdata_next = {underrun_cnt_reg, 8'b0, count6, full, empty};
            1:       readdata_next = 32'(ftw_reg);
            default: readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            readdatavalid_reg <= data_in_i.read;
            if (data_in_i.read)
                readdata_reg <= readdata_next;
        end
    end
endmodule

// File: tb/tb_ddsc_freq_sink.sv
// Scoreboard bench for ddsc_freq_sink: stimulus queues expected tuning words and read
// data with their due cycle; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ddsc_freq_sink;
    localparam int SW = 34;
    localparam logic [SW-1:0] SCALE1 = 34'h1_0000_0000;
    localparam logic [SW-1:0] SCALE3 = 34'h3_0000_0000;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync = 1'b0;
    logic apply_on_sync = 1'b1;
    logic [SW-1:0] ftw_scale = SCALE1;
    logic [31:0] ftw;
    logic ftw_stb, underrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int under_seen = 0;
    exp_t ftw_q[$];
    exp_t rd_q[$];
    logic [31:0] model[$];

    avmm_if #(.DW(32), .AW(4)) bus ();

    ddsc_freq_sink #(.DW(32), .FIFO_AW(2), .SCALE_W(SW), .SHIFT(32), .FTW_W(32)) dut (
        .clk(clk), .rst(rst), .data_in_i(bus.slave), .sync(sync),
        .apply_on_sync(apply_on_sync), .ftw_scale(ftw_scale),
        .ftw(ftw), .ftw_stb(ftw_stb), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end else
            $display("ok   %s: 0x%08h", name, act);
    endtask

    // Output monitor: pops the scoreboards whenever the DUT presents a strobe or read data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (underrun) under_seen++;
            if (ftw_stb) begin
                if (ftw_q.size() == 0) begin
                    chk("unexpected_ftw_stb", 32'd1, 32'd0);
                end else begin
                    e = ftw_q.pop_front();
                    chk("ftw_value", ftw, e.v);
                    chk("ftw_stb_cycle", 32'(cyc), 32'(e.c));
                end
            end
            if (bus.readdatavalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_readdatavalid", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("readdata", bus.readdata, e.v);
                    chk("readdatavalid_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [31:0] d, output int stalls);
        stalls = 0;
        bus.write = 1'b1;
        bus.writedata = d;
        forever begin
            @(negedge clk);
            if (!bus.waitrequest) break;
            stalls++;
            if (stalls > 50) begin
                chk("write_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        if (stalls <= 50) model.push_back(d);
        #1 bus.write = 1'b0;
    endtask

    task automatic pulse_sync(input bit expect_data);
        logic [65:0] p;
        logic [31:0] w;
        exp_t e;
        sync = 1'b1;
        if (model.size() > 0) begin
            w = model.pop_front();
            p = 66'(w) * 66'(ftw_scale);
            e.v = p[63:32];
            e.c = cyc + 3;
            if (expect_data) ftw_q.push_back(e);
        end
        @(posedge clk);
        #1 sync = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] expv);
        exp_t e;
        bus.read = 1'b1;
        bus.address = a;
        e.v = expv;
        e.c = cyc + 1;
        rd_q.push_back(e);
        @(posedge clk);
        #1 bus.read = 1'b0;
        bus.address = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int n0;
        int u0;
        exp_t e;
        bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0; bus.address = '0;
        bus.byteenable = '0; bus.burstcount = 4'd1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ftw", ftw, 32'd0);
        chk("reset_ftw_stb", 32'(ftw_stb), 32'd0);
        chk("reset_waitrequest", 32'(bus.waitrequest), 32'd0);
        chk("reset_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        @(posedge clk); #1;

        // Sync mode: three words released 10 cycles apart.
        ftw_scale = SCALE1;
        apply_on_sync = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            do_write(32'(100 * i), st);
            chk("sync_write_no_stall", 32'(st), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_sync(1'b1);
            idle(9);
        end

        // Fill to depth 4, then the 5th and 6th writes each need a sync to get in.
        for (int i = 11; i <= 14; i++) begin
            do_write(32'(i), st);
            chk("fill_write_no_stall", 32'(st), 32'd0);
        end
        fork
            do_write(32'd15, st);
            begin
                @(negedge clk);
                chk("full_waitrequest", 32'(bus.waitrequest), 32'd1);
                @(posedge clk); #1;
                pulse_sync(1'b1);
            end
        join
        chk("write5_stalls", 32'(st), 32'd2);
        fork
            do_write(32'd16, st);
            begin
                @(negedge clk);
                chk("refull_waitrequest", 32'(bus.waitrequest), 32'd1);
                @(posedge clk); #1;
                pulse_sync(1'b1);
            end
        join
        chk("write6_stalls", 32'(st), 32'd2);
        for (int i = 0; i < 4; i++) begin
            pulse_sync(1'b1);
            idle(2);
        end
        idle(6);

        // Immediate mode: four queued words drain on consecutive cycles.
        ftw_scale = SCALE3;
        for (int i = 1; i <= 4; i++) do_write(32'(i), st);
        apply_on_sync = 1'b0;
        n0 = cyc;
        e.v = 32'd3;  e.c = n0 + 3; ftw_q.push_back(e);
        e.v = 32'd6;  e.c = n0 + 4; ftw_q.push_back(e);
        e.v = 32'd9;  e.c = n0 + 5; ftw_q.push_back(e);
        e.v = 32'd12; e.c = n0 + 6; ftw_q.push_back(e);
        model.delete();
        idle(8);
        do_read(4'd0, 32'h0000_0001);
        idle(2);

        // Underruns on an empty FIFO in sync mode.
        apply_on_sync = 1'b1;
        u0 = under_seen;
        for (int i = 0; i < 3; i++) begin
            pulse_sync(1'b0);
            idle(3);
        end
        chk("underrun_pulses", 32'(under_seen - u0), 32'd3);
        @(negedge clk);
        chk("ftw_held_after_underrun", ftw, 32'd12);
        @(posedge clk); #1;
        do_read(4'd0, 32'h0003_0001);
        idle(2);

        // Readback of the last tuning word and of an unmapped address.
        ftw_scale = SCALE1;
        do_write(32'h1234, st);
        pulse_sync(1'b1);
        idle(5);
        do_read(4'd1, 32'h0000_1234);
        do_read(4'd5, 32'h0000_0000);
        idle(3);

        // Reset with one word in the multiply stage and two still queued.
        for (int i = 1; i <= 3; i++) do_write(32'(50 + i), st);
        pulse_sync(1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model.delete();
        idle(6);
        @(negedge clk);
        chk("ftw_after_midflight_reset", ftw, 32'd0);
        @(posedge clk); #1;
        do_read(4'd0, 32'h0000_0001);

        for (int i = 0; i < 50 && (ftw_q.size() != 0 || rd_q.size() != 0); i++)
            @(posedge clk);
        idle(2);
        chk("ftw_scoreboard_drained", 32'(ftw_q.size()), 32'd0);
        chk("read_scoreboard_drained", 32'(rd_q.size()), 32'd0);
        chk("total_underruns", 32'(under_seen), 32'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
